// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the unified-memory port arbiter.
//   - DEF_AW / DEF_DW : default address/data widths, shared with pipeline_cpu
//   - arb_state_t     : arbiter sequencing states (IDLE -> ACCESS -> DONE)
//   - owner_t         : which requester owns the current access (fetch or data)
package mem_port_arbiter_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch port, data port and memory-macro port of the arbiter.
//   Modports:
//     slave  : the arbiter (takes requests + mem_rdata, drives grants/valids/stalls/mem_*)
//     master : the surroundings (pipeline stages + memory macro)
//   Fetch  : i_req, i_addr -> i_gnt, i_valid, i_rdata, stall_if
//   Data   : d_req, d_we, d_addr, d_wdata -> d_gnt, d_valid, d_rdata, stall_mem
//   Memory : mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata
//   AW/DW must match the arbiter instance's AW/DW.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);

  // Fetch port
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_valid;
  logic [DW-1:0] i_rdata;
  logic          stall_if;

  // Data port
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_valid;
  logic [DW-1:0] d_rdata;
  logic          stall_mem;

  // Memory macro port
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_valid, i_rdata, stall_if,
    output d_gnt, d_valid, d_rdata, stall_mem,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_valid, i_rdata, stall_if,
    input  d_gnt, d_valid, d_rdata, stall_mem,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
//   Combinational winner selection for the arbiter.
//   Data requests win by default so the MEM stage drains first, except when a
//   fetch is pending and data has already taken MAX_D_STREAK grants in a row.
//   Ports:
//     i_req  in  fetch request
//     d_req  in  data request
//     streak in  consecutive data grants taken while a fetch was waiting
//     owner  out winner (only meaningful when i_req | d_req)
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4,
  parameter int SW           = 3
) (
  input  logic          i_req,
  input  logic          d_req,
  input  logic [SW-1:0] streak,
  output owner_t        owner
);

  logic starve_i;

  assign starve_i = i_req && (streak == SW'(MAX_D_STREAK));
  assign owner    = (d_req && !starve_i) ? OWN_D : OWN_I;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between instruction fetch and LOAD/STORE.
//   Each access runs IDLE -> ACCESS (MEM_LAT cycles) -> DONE -> IDLE, so one
//   access completes every MEM_LAT+2 cycles. Grants and valids are one-cycle
//   pulses to the winner only; the stall outputs keep the pipeline frozen
//   until the matching valid pulse.
//   Ports:
//     clock   in  system clock, all state on rising edge
//     reset   in  synchronous active-high reset
//     enable  in  0 blocks new grants; an access already started completes
//     bus     slave side of mem_port_arbiter_if (fetch, data and memory ports)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter int MEM_LAT      = 2,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  mem_port_arbiter_if.slave   bus
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(MAX_D_STREAK + 1);

  arb_state_t    state_reg;
  owner_t        owner_reg;
  owner_t        owner_next;
  logic [CW-1:0] cnt_reg;
  logic [SW-1:0] streak_reg;

  logic          i_gnt_reg;
  logic          d_gnt_reg;
  logic          i_valid_reg;
  logic          d_valid_reg;
  logic [DW-1:0] i_rdata_reg;
  logic [DW-1:0] d_rdata_reg;
  logic          mem_en_reg;
  logic          mem_we_reg;
  logic [AW-1:0] mem_addr_reg;
  logic [DW-1:0] mem_wdata_reg;

  mem_arb_pick #(
    .MAX_D_STREAK (MAX_D_STREAK),
    .SW           (SW)
  ) u_pick (
    .i_req  (bus.i_req),
    .d_req  (bus.d_req),
    .streak (streak_reg),
    .owner  (owner_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      owner_reg     <= OWN_I;
      cnt_reg       <= '0;
      streak_reg    <= '0;
      i_gnt_reg     <= 1'b0;
      d_gnt_reg     <= 1'b0;
      i_valid_reg   <= 1'b0;
      d_valid_reg   <= 1'b0;
      i_rdata_reg   <= '0;
      d_rdata_reg   <= '0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      // Grant and valid are single-cycle pulses.
      i_gnt_reg   <= 1'b0;
      d_gnt_reg   <= 1'b0;
      i_valid_reg <= 1'b0;
      d_valid_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (enable && (bus.i_req || bus.d_req)) begin
            state_reg  <= ST_ACCESS;
            owner_reg  <= owner_next;
            cnt_reg    <= CW'(MEM_LAT - 1);
            mem_en_reg <= 1'b1;
            if (owner_next == OWN_D) begin
              d_gnt_reg     <= 1'b1;
              mem_we_reg    <= bus.d_we;
              mem_addr_reg  <= bus.d_addr;
              mem_wdata_reg <= bus.d_wdata;
              // Count only the data grants that made a waiting fetch wait longer.
              streak_reg    <= bus.i_req ? streak_reg + SW'(1) : '0;
            end else begin
              i_gnt_reg    <= 1'b1;
              mem_we_reg   <= 1'b0;
              mem_addr_reg <= bus.i_addr;
              streak_reg   <= '0;
            end
          end
        end

        ST_ACCESS: begin
          if (cnt_reg == '0) begin
            // mem_rdata is valid in this last access cycle.
            state_reg  <= ST_DONE;
            mem_en_reg <= 1'b0;
            mem_we_reg <= 1'b0;
            if (owner_reg == OWN_D) begin
              d_valid_reg <= 1'b1;
              if (!mem_we_reg) begin
                d_rdata_reg <= bus.mem_rdata;
              end
            end else begin
              i_valid_reg <= 1'b1;
              i_rdata_reg <= bus.mem_rdata;
            end
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end

        // No grant here: the requester still holds its old req during DONE.
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.i_gnt     = i_gnt_reg;
  assign bus.d_gnt     = d_gnt_reg;
  assign bus.i_valid   = i_valid_reg;
  assign bus.d_valid   = d_valid_reg;
  assign bus.i_rdata   = i_rdata_reg;
  assign bus.d_rdata   = d_rdata_reg;
  assign bus.mem_en    = mem_en_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;

  assign bus.stall_if  = bus.i_req & ~i_valid_reg;
  assign bus.stall_mem = bus.d_req & ~d_valid_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter (MEM_LAT=2, MAX_D_STREAK=4).
//   Cycle 0 is the cycle whose closing edge samples the new requests; each
//   scenario records per-cycle bitmasks of the handshake outputs and compares
//   them to hand-derived masks.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic enable;

  always #5 clock = ~clock;

  mem_port_arbiter_if #(.AW(8), .DW(16)) bus ();

  mem_port_arbiter #(
    .AW           (8),
    .DW           (16),
    .MEM_LAT      (2),
    .MAX_D_STREAK (4)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .bus    (bus)
  );

  // Memory macro model: fixed read pattern, writes are logged.
  function automatic logic [15:0] mem_pattern(input logic [7:0] a);
    case (a)
      8'h10:   return 16'hABCD;
      8'h20:   return 16'h1111;
      8'h30:   return 16'h5A5A;
      default: return {8'hC0, a};
    endcase
  endfunction

  assign bus.mem_rdata = mem_pattern(bus.mem_addr);

  logic [7:0]  last_wr_addr = 8'h00;
  logic [15:0] last_wr_data = 16'h0000;

  always @(posedge clock) begin
    if (bus.mem_en && bus.mem_we) begin
      last_wr_addr <= bus.mem_addr;
      last_wr_data <= bus.mem_wdata;
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc;
  logic [63:0] i_gnt_v, i_valid_v, d_gnt_v, d_valid_v;
  logic [63:0] mem_en_v, mem_we_v, stall_if_v, stall_mem_v;
  logic [15:0] i_rdata_seen, d_rdata_seen, wdata_c1;
  logic [7:0]  addr_c1;
  bit drop_i, drop_d;

  task automatic obs();
    logic [5:0] b;
    b = cyc[5:0];
    i_gnt_v[b]     = bus.i_gnt;
    i_valid_v[b]   = bus.i_valid;
    d_gnt_v[b]     = bus.d_gnt;
    d_valid_v[b]   = bus.d_valid;
    mem_en_v[b]    = bus.mem_en;
    mem_we_v[b]    = bus.mem_we;
    stall_if_v[b]  = bus.stall_if;
    stall_mem_v[b] = bus.stall_mem;
    if (bus.i_valid) i_rdata_seen = bus.i_rdata;
    if (bus.d_valid) d_rdata_seen = bus.d_rdata;
    if (cyc == 1) begin
      addr_c1  = bus.mem_addr;
      wdata_c1 = bus.mem_wdata;
    end
  endtask

  // Advance n cycles; requesters drop their req in the valid cycle.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
      cyc++;
      obs();
      if (drop_i && bus.i_valid) bus.i_req = 1'b0;
      if (drop_d && bus.d_valid) bus.d_req = 1'b0;
    end
  endtask

  task automatic start_test();
    i_gnt_v = '0; i_valid_v = '0; d_gnt_v = '0; d_valid_v = '0;
    mem_en_v = '0; mem_we_v = '0; stall_if_v = '0; stall_mem_v = '0;
    i_rdata_seen = '0; d_rdata_seen = '0; wdata_c1 = '0; addr_c1 = '0;
    drop_i = 1'b1;
    drop_d = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.i_req = 1'b1;
    bus.i_addr = 8'h10;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({bus.i_gnt, bus.d_gnt, bus.i_valid, bus.d_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_handshake: got %b expected 0000", {bus.i_gnt, bus.d_gnt, bus.i_valid, bus.d_valid});
    end
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 26'h0) begin
      errors++;
      $display("FAIL reset_mem: got %h expected 0", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata});
    end
    checks++;
    if ({bus.i_rdata, bus.d_rdata} !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h expected 0", {bus.i_rdata, bus.d_rdata});
    end
    checks++;
    if ({bus.stall_if, bus.stall_mem} !== 2'b10) begin
      errors++;
      $display("FAIL reset_stall: got %b expected 10", {bus.stall_if, bus.stall_mem});
    end
    bus.d_req = 1'b1;
    #1;
    checks++;
    if (bus.stall_mem !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall_mem: got %b expected 1", bus.stall_mem);
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    $display("reset: done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_iread();
    start_test();
    bus.i_addr = 8'h10;
    bus.i_req  = 1'b1;
    #1; obs();
    step(6);
    checks++;
    if (i_gnt_v !== 64'h2) begin errors++; $display("FAIL iread_gnt: got %h expected %h", i_gnt_v, 64'h2); end
    checks++;
    if (mem_en_v !== 64'h6) begin errors++; $display("FAIL iread_mem_en: got %h expected %h", mem_en_v, 64'h6); end
    checks++;
    if (mem_we_v !== 64'h0) begin errors++; $display("FAIL iread_mem_we: got %h expected 0", mem_we_v); end
    checks++;
    if (addr_c1 !== 8'h10) begin errors++; $display("FAIL iread_addr: got %h expected 10", addr_c1); end
    checks++;
    if (i_valid_v !== 64'h8) begin errors++; $display("FAIL iread_valid: got %h expected %h", i_valid_v, 64'h8); end
    checks++;
    if (i_rdata_seen !== 16'hABCD) begin errors++; $display("FAIL iread_rdata: got %h expected abcd", i_rdata_seen); end
    checks++;
    if (d_gnt_v !== 64'h0) begin errors++; $display("FAIL iread_no_dgnt: got %h expected 0", d_gnt_v); end
    checks++;
    if (stall_if_v !== 64'h7) begin errors++; $display("FAIL iread_stall_if: got %h expected %h", stall_if_v, 64'h7); end
    $display("iread: addr=10 rdata=%h checks=%0d errors=%0d", i_rdata_seen, checks, errors);
  endtask

  task automatic test_collision();
    start_test();
    bus.d_we   = 1'b0;
    bus.d_addr = 8'h30;
    bus.d_req  = 1'b1;
    bus.i_addr = 8'h20;
    bus.i_req  = 1'b1;
    #1; obs();
    step(10);
    checks++;
    if (d_gnt_v !== 64'h2) begin errors++; $display("FAIL coll_d_gnt: got %h expected %h", d_gnt_v, 64'h2); end
    checks++;
    if (d_valid_v !== 64'h8) begin errors++; $display("FAIL coll_d_valid: got %h expected %h", d_valid_v, 64'h8); end
    checks++;
    if (i_gnt_v !== 64'h20) begin errors++; $display("FAIL coll_i_gnt: got %h expected %h", i_gnt_v, 64'h20); end
    checks++;
    if (i_valid_v !== 64'h80) begin errors++; $display("FAIL coll_i_valid: got %h expected %h", i_valid_v, 64'h80); end
    checks++;
    if (stall_if_v !== 64'h7F) begin errors++; $display("FAIL coll_stall_if: got %h expected %h", stall_if_v, 64'h7F); end
    checks++;
    if (stall_mem_v !== 64'h7) begin errors++; $display("FAIL coll_stall_mem: got %h expected %h", stall_mem_v, 64'h7); end
    checks++;
    if (mem_en_v !== 64'h66) begin errors++; $display("FAIL coll_mem_en: got %h expected %h", mem_en_v, 64'h66); end
    checks++;
    if (d_rdata_seen !== 16'h5A5A) begin errors++; $display("FAIL coll_d_rdata: got %h expected 5a5a", d_rdata_seen); end
    checks++;
    if (i_rdata_seen !== 16'h1111) begin errors++; $display("FAIL coll_i_rdata: got %h expected 1111", i_rdata_seen); end
    $display("collision: d=%h i=%h checks=%0d errors=%0d", d_rdata_seen, i_rdata_seen, checks, errors);
  endtask

  task automatic test_store();
    start_test();
    bus.d_we    = 1'b1;
    bus.d_addr  = 8'h05;
    bus.d_wdata = 16'h1234;
    bus.d_req   = 1'b1;
    #1; obs();
    step(6);
    bus.d_we = 1'b0;
    checks++;
    if (mem_we_v !== 64'h6) begin errors++; $display("FAIL store_mem_we: got %h expected %h", mem_we_v, 64'h6); end
    checks++;
    if (mem_en_v !== 64'h6) begin errors++; $display("FAIL store_mem_en: got %h expected %h", mem_en_v, 64'h6); end
    checks++;
    if ({addr_c1, wdata_c1} !== 24'h051234) begin errors++; $display("FAIL store_bus: got %h expected 051234", {addr_c1, wdata_c1}); end
    checks++;
    if (d_valid_v !== 64'h8) begin errors++; $display("FAIL store_valid: got %h expected %h", d_valid_v, 64'h8); end
    checks++;
    if (d_rdata_seen !== 16'h5A5A) begin errors++; $display("FAIL store_d_rdata: got %h expected 5a5a", d_rdata_seen); end
    checks++;
    if ({last_wr_addr, last_wr_data} !== 24'h051234) begin errors++; $display("FAIL store_written: got %h expected 051234", {last_wr_addr, last_wr_data}); end
    $display("store: addr=05 data=1234 checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_starvation();
    start_test();
    drop_i = 1'b0;
    drop_d = 1'b0;
    bus.d_we   = 1'b0;
    bus.d_addr = 8'h30;
    bus.d_req  = 1'b1;
    bus.i_addr = 8'h40;
    bus.i_req  = 1'b1;
    #1; obs();
    step(19);
    // A new fetch arrives right away; the streak must have restarted.
    bus.i_addr = 8'h41;
    step(3);
    bus.d_req = 1'b0;
    bus.i_req = 1'b0;
    step(6);
    checks++;
    if (d_gnt_v !== 64'h202222) begin errors++; $display("FAIL starve_d_gnt: got %h expected %h", d_gnt_v, 64'h202222); end
    checks++;
    if (i_gnt_v !== 64'h20000) begin errors++; $display("FAIL starve_i_gnt: got %h expected %h", i_gnt_v, 64'h20000); end
    checks++;
    if (i_valid_v !== 64'h80000) begin errors++; $display("FAIL starve_i_valid: got %h expected %h", i_valid_v, 64'h80000); end
    checks++;
    if (d_valid_v !== 64'h808888) begin errors++; $display("FAIL starve_d_valid: got %h expected %h", d_valid_v, 64'h808888); end
    checks++;
    if (stall_if_v[16:0] !== 17'h1FFFF) begin errors++; $display("FAIL starve_stall_if: got %h expected 1ffff", stall_if_v[16:0]); end
    $display("starvation: d_gnt=%h i_gnt=%h checks=%0d errors=%0d", d_gnt_v, i_gnt_v, checks, errors);
  endtask

  task automatic test_enable();
    start_test();
    enable = 1'b0;
    bus.d_we   = 1'b0;
    bus.d_addr = 8'h30;
    bus.d_req  = 1'b1;
    bus.i_addr = 8'h20;
    bus.i_req  = 1'b1;
    #1; obs();
    step(5);
    enable = 1'b1;
    step(2);
    enable = 1'b0;
    step(5);
    enable = 1'b1;
    step(5);
    checks++;
    if (d_gnt_v !== 64'h40) begin errors++; $display("FAIL enable_d_gnt: got %h expected %h", d_gnt_v, 64'h40); end
    checks++;
    if (d_valid_v !== 64'h100) begin errors++; $display("FAIL enable_d_valid: got %h expected %h", d_valid_v, 64'h100); end
    checks++;
    if (i_gnt_v !== 64'h2000) begin errors++; $display("FAIL enable_i_gnt: got %h expected %h", i_gnt_v, 64'h2000); end
    checks++;
    if (i_valid_v !== 64'h8000) begin errors++; $display("FAIL enable_i_valid: got %h expected %h", i_valid_v, 64'h8000); end
    checks++;
    if (mem_en_v !== 64'h60C0) begin errors++; $display("FAIL enable_mem_en: got %h expected %h", mem_en_v, 64'h60C0); end
    checks++;
    if (stall_if_v !== 64'h7FFF) begin errors++; $display("FAIL enable_stall_if: got %h expected %h", stall_if_v, 64'h7FFF); end
    $display("enable: d_gnt=%h i_gnt=%h checks=%0d errors=%0d", d_gnt_v, i_gnt_v, checks, errors);
  endtask

  task automatic test_abort();
    start_test();
    bus.i_addr = 8'h10;
    bus.i_req  = 1'b1;
    #1; obs();
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    bus.i_req = 1'b0;
    step(4);
    checks++;
    if (i_gnt_v !== 64'h2) begin errors++; $display("FAIL abort_gnt: got %h expected %h", i_gnt_v, 64'h2); end
    checks++;
    if (mem_en_v !== 64'h6) begin errors++; $display("FAIL abort_mem_en: got %h expected %h", mem_en_v, 64'h6); end
    checks++;
    if (i_valid_v !== 64'h0) begin errors++; $display("FAIL abort_valid: got %h expected 0", i_valid_v); end
    checks++;
    if (bus.i_rdata !== 16'h0) begin errors++; $display("FAIL abort_rdata: got %h expected 0", bus.i_rdata); end
    $display("abort: mem_en=%h i_valid=%h checks=%0d errors=%0d", mem_en_v, i_valid_v, checks, errors);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset       = 1'b1;
    enable      = 1'b1;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    test_reset();
    test_iread();
    test_collision();
    test_store();
    test_starvation();
    test_enable();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
